bram_acq_writer: RTL and testbench

- Capture side of the BRAM acquisition path: takes the FFT spectrum stream and writes one aligned buffer of DEPTH words into a BRAM port.
- Exports the running write count as the 32-bit status word that the PS-side completion monitor compares against its near-full window.
- Armed by a PS GPIO level. Captures only from a frame boundary, then stops and holds until re-armed.

---
 rtl/bram_acq_writer_pkg.sv | 18 +
 rtl/bram_acq_writer_if.sv | 33 +++
 rtl/bram_acq_writer_frame_checker.sv | 52 +++++
 rtl/bram_acq_writer.sv | 121 ++++++++++++
 tb/tb_bram_acq_writer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_acq_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_acq_writer_pkg
// Purpose  : Shared state encoding and BRAM constants for the acquisition writer.
// Revision : 1.0  initial release
// ============================================================================
package bram_acq_writer_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam int         BYTE_SHIFT  = 2;
  localparam logic [3:0] WE_ALL      = 4'hF;

endpackage
`default_nettype wire

// File: rtl/bram_acq_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_acq_writer_if
// Purpose  : FFT stream input and BRAM write port bundled for the writer.
// Revision : 1.0  initial release
// ============================================================================
interface bram_acq_writer_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [31:0]       bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [3:0]        bram_we;
  logic              bram_en;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  bram_addr, bram_din, bram_we, bram_en
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output bram_addr, bram_din, bram_we, bram_en
  );

endinterface
`default_nettype wire

// File: rtl/bram_acq_writer_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : acq_frame_checker
// Purpose  : Tracks frame position of captured beats; flags misplaced tlast.
// Revision : 1.0  initial release
// ============================================================================
module acq_frame_checker #(
  parameter int FRAME_LEN = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic beat,
  input  wire logic tlast,
  output logic      sync_err
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (beat) begin
      // No realignment: a mismatch is recorded but the count keeps its phase.
      if (tlast != at_end) err_d = 1'b1;
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign sync_err = err_q;

endmodule
`default_nettype wire

// File: rtl/bram_acq_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_acq_writer
// Purpose  : Arms on a GPIO edge, waits for a frame boundary, writes DEPTH words.
// Revision : 1.0  initial release
// ============================================================================
module bram_acq_writer
  import bram_acq_writer_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1024
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         arm,
  bram_acq_writer_if.slave  bus,
  output logic [31:0]       status,
  output logic              busy,
  output logic              done,
  output logic              sync_err
);

  logic [1:0]        state_q, state_d;
  logic [31:0]       status_q, status_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        we_q, we_d;
  logic              arm_q;
  logic              tready_q;
  logic              arm_rise;
  logic              beat;
  logic              wr_beat;
  logic              chk_clear;

  assign arm_rise = arm & ~arm_q;
  assign beat     = bus.s_axis_tvalid;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = '0;
    wr_beat   = 1'b0;
    chk_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          status_d  = '0;
          chk_clear = 1'b1;
          state_d   = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        if (!arm)                            state_d = ST_IDLE;
        else if (beat && bus.s_axis_tlast)   state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          wr_beat  = 1'b1;
          we_d     = WE_ALL;
          addr_d   = {{(32-ADDR_W-BYTE_SHIFT){1'b0}}, status_q[ADDR_W-1:0], {BYTE_SHIFT{1'b0}}};
          din_d    = bus.s_axis_tdata;
          status_d = status_q + 32'd1;
          if (status_q == 32'(DEPTH - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!arm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      status_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= '0;
      // Treat arm as already seen so a level held through reset is not an edge.
      arm_q    <= 1'b1;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      arm_q    <= arm;
      tready_q <= 1'b1;
    end
  end

  acq_frame_checker #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (chk_clear),
    .beat     (wr_beat),
    .tlast    (bus.s_axis_tlast),
    .sync_err (sync_err)
  );

  assign bus.s_axis_tready = tready_q;
  assign bus.bram_addr     = addr_q;
  assign bus.bram_din      = din_q;
  assign bus.bram_we       = we_q;
  assign bus.bram_en       = |we_q;
  assign status            = status_q;
  assign busy              = (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
  assign done              = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bram_acq_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_acq_writer
// Purpose  : Directed self-checking bench for the BRAM acquisition writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_acq_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [31:0] status;
  logic        busy, done, sync_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:1023];
  int          wr_cnt = 0;
  int          consec = 0;
  int          en_bad = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] last_addr  = '0;
  logic        prev_we    = 1'b0;
  logic [31:0] mid_status = '0;

  bram_acq_writer_if #(.DATA_W(32)) bus ();

  bram_acq_writer #(
    .DEPTH     (1024),
    .ADDR_W    (10),
    .DATA_W    (32),
    .FRAME_LEN (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .bus      (bus.slave),
    .status   (status),
    .busy     (busy),
    .done     (done),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // BRAM model: commits whatever the port presents at each rising edge.
  always @(posedge clk) begin
    if (bus.bram_en !== (|bus.bram_we)) en_bad++;
    if (bus.bram_we == 4'hF) begin
      if (wr_cnt == 0) first_addr = bus.bram_addr;
      last_addr = bus.bram_addr;
      mem[bus.bram_addr[11:2]] = bus.bram_din;
      wr_cnt++;
    end
    if ((bus.bram_we != 4'h0) && prev_we) consec++;
    prev_we = (bus.bram_we != 4'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEADBEEF;
    wr_cnt = 0;
    consec = 0;
    en_bad = 0;
  endtask

  task automatic arm_start();
    arm = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    arm = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
  endtask

  // Five junk beats, the start-of-frame tlast beat, then n capture beats.
  task automatic capture(input int base, input int gap, input int bad_last, input int n);
    for (int j = 0; j < 5; j++) drive(1'b1, 32'hBAD0_0000 + j, 1'b0);
    drive(1'b1, 32'hBAD0_FFFF, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (gap != 0) drive(1'b0, 32'h0, 1'b0);
      drive(1'b1, base + i, (i == 1023) || (i == bad_last));
      if (i == 1000) mid_status = status;
    end
  endtask

  function automatic int mem_errors(input int base);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 32'(base + i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    arm = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (status !== 32'd0) begin tests_failed++; $display("FAIL reset_status got %0d want 0", status); end
    tests_run++; if (bus.bram_we !== 4'h0 || bus.bram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_we got we=%h en=%b want 0/0", bus.bram_we, bus.bram_en); end
    tests_run++; if (bus.s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready got %b want 0", bus.s_axis_tready); end
    tests_run++; if ({busy, done, sync_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {busy, done, sync_err}); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (bus.s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL tready_after_reset got %b want 1", bus.s_axis_tready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL arm_held_no_start busy got %b want 0", busy); end
  endtask

  task automatic test_full_capture();
    clear_model();
    arm_start();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL arm_busy got %b want 1", busy); end
    capture(0, 0, -1, 1024);
    tests_run++; if (status !== 32'd1024 || done !== 1'b1) begin tests_failed++; $display("FAIL full_end got status=%0d done=%b want 1024/1", status, done); end
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (mid_status !== 32'd1001) begin tests_failed++; $display("FAIL full_mid_status got %0d want 1001", mid_status); end
    tests_run++; if (mem_errors(0) !== 0) begin tests_failed++; $display("FAIL full_mem got %0d bad words want 0", mem_errors(0)); end
    tests_run++; if (wr_cnt !== 1024) begin tests_failed++; $display("FAIL full_wr_cnt got %0d want 1024", wr_cnt); end
    tests_run++; if (first_addr !== 32'h0 || last_addr !== 32'hFFC) begin tests_failed++; $display("FAIL full_addr got first=%h last=%h want 0/ffc", first_addr, last_addr); end
    tests_run++; if (sync_err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL full_flags got sync_err=%b busy=%b want 0/0", sync_err, busy); end
    tests_run++; if (en_bad !== 0) begin tests_failed++; $display("FAIL full_en_match got %0d bad cycles want 0", en_bad); end
  endtask

  task automatic test_gapped();
    clear_model();
    arm_start();
    capture(0, 1, -1, 1024);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (mem_errors(0) !== 0) begin tests_failed++; $display("FAIL gap_mem got %0d bad words want 0", mem_errors(0)); end
    tests_run++; if (wr_cnt !== 1024) begin tests_failed++; $display("FAIL gap_wr_cnt got %0d want 1024", wr_cnt); end
    tests_run++; if (consec !== 0) begin tests_failed++; $display("FAIL gap_we_pulses got %0d back-to-back want 0", consec); end
    tests_run++; if (status !== 32'd1024 || done !== 1'b1) begin tests_failed++; $display("FAIL gap_end got status=%0d done=%b want 1024/1", status, done); end
  endtask

  task automatic test_sync_err();
    clear_model();
    arm_start();
    capture(100, 0, 499, 1024);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL sync_set got %b want 1", sync_err); end
    tests_run++; if (status !== 32'd1024 || done !== 1'b1) begin tests_failed++; $display("FAIL sync_complete got status=%0d done=%b want 1024/1", status, done); end
    tests_run++; if (mem_errors(100) !== 0) begin tests_failed++; $display("FAIL sync_mem got %0d bad words want 0", mem_errors(100)); end
    arm = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (sync_err !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL sync_sticky got sync_err=%b done=%b want 1/0", sync_err, done); end
    arm = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (sync_err !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL sync_clear got sync_err=%b busy=%b want 0/1", sync_err, busy); end
  endtask

  task automatic test_abort();
    clear_model();
    arm_start();
    capture(0, 0, -1, 300);
    arm = 1'b0;
    for (int i = 300; i < 310; i++) drive(1'b1, i, 1'b0);
    tests_run++; if (status !== 32'd300) begin tests_failed++; $display("FAIL abort_status got %0d want 300", status); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle got busy=%b done=%b want 0/0", busy, done); end
    tests_run++; if (wr_cnt !== 300 || last_addr !== 32'd1196) begin tests_failed++; $display("FAIL abort_writes got cnt=%0d last=%h want 300/4ac", wr_cnt, last_addr); end
  endtask

  task automatic test_rst_mid();
    clear_model();
    arm_start();
    capture(0, 0, -1, 700);
    rst = 1'b1;
    drive(1'b1, 32'd700, 1'b0);
    tests_run++; if (status !== 32'd0 || bus.bram_addr !== 32'd0 || bus.bram_din !== 32'd0) begin tests_failed++; $display("FAIL rst_regs got status=%0d addr=%h din=%h want 0/0/0", status, bus.bram_addr, bus.bram_din); end
    tests_run++; if (bus.bram_we !== 4'h0 || bus.bram_en !== 1'b0 || bus.s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL rst_port got we=%h en=%b tready=%b want 0/0/0", bus.bram_we, bus.bram_en, bus.s_axis_tready); end
    tests_run++; if ({busy, done, sync_err} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags got %b want 000", {busy, done, sync_err}); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    clear_model();
    arm_start();
    capture(5000, 0, -1, 1024);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (mem_errors(5000) !== 0 || wr_cnt !== 1024) begin tests_failed++; $display("FAIL rst_recapture got bad=%0d cnt=%0d want 0/1024", mem_errors(5000), wr_cnt); end
    tests_run++; if (first_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_first_addr got %h want 0", first_addr); end
  endtask

  task automatic test_after_done();
    wr_cnt = 0;
    arm = 1'b1;
    for (int i = 0; i < 40; i++) drive(1'b1, 32'h7000 + i, (i % 8) == 7);
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL done_no_write got %0d writes want 0", wr_cnt); end
    tests_run++; if (status !== 32'd1024 || done !== 1'b1) begin tests_failed++; $display("FAIL done_hold got status=%0d done=%b want 1024/1", status, done); end
    arm = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (done !== 1'b0 || busy !== 1'b0 || status !== 32'd1024) begin tests_failed++; $display("FAIL done_release got done=%b busy=%b status=%0d want 0/0/1024", done, busy, status); end
    arm = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tests_run++; if (busy !== 1'b1 || status !== 32'd0) begin tests_failed++; $display("FAIL done_rearm got busy=%b status=%0d want 1/0", busy, status); end
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    test_reset();
    test_full_capture();
    test_gapped();
    test_sync_err();
    test_abort();
    test_rst_mid();
    test_after_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
